alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
- REQ-001: Parameter DEPTH, default 4, command FIFO depth; power of two, at least 2.
- REQ-002: clk  in  1  single clock; all logic on its rising edge.
- REQ-003: rst_n  in  1  reset, synchronous, active-low.
- REQ-004: cmd_valid  in  1  command offered.
- REQ-005: cmd_ready  out  1  command slot free.
- REQ-006: cmd_opcode  in  3  ALU opcode, 0..7, passed unmodified.
- REQ-007: cmd_op1, cmd_op2  in  32 each  operands.
- REQ-008: alu_opcode, alu_operand1, alu_operand2  out  3/32/32  registered drive to downstream alu_32bit.
- REQ-009: alu_result  in  32  ALU result; alu_flagC, alu_flagZ, alu_overflow, alu_zero  in  1 each  ALU flags.
- REQ-010: rsp_valid  out  1  response held.
- REQ-011: rsp_ready  in  1  response consumed.
- REQ-012: rsp_result  out  32 and rsp_flags  out  4 = {overflow, zero, flagZ, flagC}.
- REQ-013: busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
- REQ-014: Push occurs when cmd_valid && cmd_ready; cmd_ready SHALL be !full, with no combinational path from rsp_ready.
- REQ-015: FIFO pointers wrap modulo DEPTH; a push and a pop in the same cycle leave count unchanged, including when full.
- REQ-016: FSM states are IDLE, EXEC and RESP.
- REQ-017: IDLE with FIFO non-empty: pop head into alu_* registers, go to EXEC next cycle.
- REQ-018: EXEC lasts exactly one cycle, holding alu_* stable; at its end register alu_result and flags into rsp_*, set rsp_valid, go to RESP.
- REQ-019: RESP holds rsp_* and rsp_valid stable until rsp_ready.
- REQ-020: On the RESP handshake with FIFO non-empty: pop into alu_* in the same cycle and go to EXEC; with FIFO empty: clear rsp_valid next cycle and go to IDLE.
- REQ-021: Latency is 3 cycles: a command accepted in cycle N into an empty, idle block gives rsp_valid in N+3.
- REQ-022: With rsp_ready held high, throughput is 1 response per 2 cycles.
- REQ-023: alu_* outputs hold their last value in IDLE and RESP, never X after reset.
- REQ-024: Responses leave in command order; no command is lost or duplicated.

Reset
- REQ-025: On clk edge with rst_n=0: FIFO empty, FSM=IDLE, rsp_valid=0, cmd_ready=1 (next cycle), busy=0, rsp_result=0, rsp_flags=0, alu_opcode=0, alu_operand1=0, alu_operand2=0.
- REQ-026: Reset asserted mid-operation discards all queued and in-flight commands with no response emitted; a push in the reset cycle is dropped.

Configuration
- REQ-027: With ALU_SEQ_STICKY_EN defined, add input sticky_clr (1) and output sticky_flags (2) = {overflow, flagC}, each ORed in at every EXEC capture.
- REQ-028: sticky_flags clears on reset or sticky_clr; if clear and capture coincide, the captured value wins.
- REQ-029: Without ALU_SEQ_STICKY_EN, sticky_clr, sticky_flags and their logic are absent.

Structure
- REQ-030: Package alu_seq_pkg holds DATA_W=32, OPCODE_W=3, FLAG_W=4, the FSM state enum and the rsp_flags bit-index constants.
- REQ-031: The FIFO is sub-module alu_seq_fifo (DEPTH, width 67), with push/pop/full/empty and a registered head.

Verification
- REQ-032: Bench stub ALU: result = op1+op2, flagC = carry-out, flagZ = zero = (result==0), overflow = signed overflow.
- REQ-033: Reset, then opcode 1, 0+0 in cycle N -> rsp_valid in N+3, rsp_result=0, rsp_flags=4'b0110.
- REQ-034: 0xFFFFFFFF + 1 -> rsp_result=0, rsp_flags=4'b0111; with ALU_SEQ_STICKY_EN, sticky_flags=2'b01 until sticky_clr.
- REQ-035: 0x7FFFFFFF + 1 -> rsp_result=0x80000000, rsp_flags=4'b1000.
- REQ-036: rsp_ready=0 while pushing 5 commands with DEPTH=4 -> cmd_ready drops after the 4th queued; release gives 5 in-order responses, 2 cycles apart.
- REQ-037: rst_n low for 1 cycle while in EXEC with 3 queued -> rsp_valid=0, busy=0, and no further responses.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared widths, command payload, FSM state and response-flag layout for alu_op_sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned CMD_W    = OPCODE_W + 2 * DATA_W;

    // Bit positions inside rsp_flags = {overflow, zero, flagZ, flagC}
    localparam int unsigned FLAG_C_IDX    = 0;
    localparam int unsigned FLAG_FZ_IDX   = 1;
    localparam int unsigned FLAG_ZERO_IDX = 2;
    localparam int unsigned FLAG_OVF_IDX  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   op1;
        logic [DATA_W-1:0]   op2;
    } seq_cmd_t;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic flag_c,
        input logic flag_z,
        input logic zero,
        input logic overflow
    );
        logic [FLAG_W-1:0] f;
        f                = '0;
        f[FLAG_C_IDX]    = flag_c;
        f[FLAG_FZ_IDX]   = flag_z;
        f[FLAG_ZERO_IDX] = zero;
        f[FLAG_OVF_IDX]  = overflow;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO for alu_op_sequencer: power-of-two depth, register storage, head read from storage.
module alu_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives a downstream ALU one at a time and holds each result until consumed.
// Optional ALU_SEQ_STICKY_EN adds sticky_clr / sticky_flags (accumulated {overflow, flagC}).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    input  logic [DATA_W-1:0]   cmd_op1,
    input  logic [DATA_W-1:0]   cmd_op2,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [DATA_W-1:0]   alu_operand1,
    output logic [DATA_W-1:0]   alu_operand2,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_flagC,
    input  logic                alu_flagZ,
    input  logic                alu_overflow,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [FLAG_W-1:0]   rsp_flags,
`ifdef ALU_SEQ_STICKY_EN
    input  logic                sticky_clr,
    output logic [1:0]          sticky_flags,
`endif
    output logic                busy
);

    seq_state_t       state;
    seq_cmd_t         wr_cmd;
    seq_cmd_t         head;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_c;
    logic             pop_c;

    assign wr_cmd    = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2};
    assign head      = seq_cmd_t'(head_bits);
    assign cmd_ready = !fifo_full;
    assign push_c    = cmd_valid && cmd_ready;
    // Head leaves when idle, or when the held response is consumed
    assign pop_c     = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    assign busy      = !fifo_empty || (state != ST_IDLE);

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (wr_cmd),
        .pop   (pop_c),
        .head  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            alu_opcode   <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        alu_opcode   <= head.opcode;
                        alu_operand1 <= head.op1;
                        alu_operand2 <= head.op2;
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= pack_flags(alu_flagC, alu_flagZ, alu_zero, alu_overflow);
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop_c) begin
                            alu_opcode   <= head.opcode;
                            alu_operand1 <= head.op1;
                            alu_operand2 <= head.op2;
                            state        <= ST_EXEC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STICKY_EN
    // A capture coinciding with a clear keeps the freshly captured flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (state == ST_EXEC) begin
            sticky_flags <= {alu_overflow, alu_flagC} | (sticky_clr ? 2'b00 : sticky_flags);
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with an adder stub standing in for alu_32bit.
module tb_alu_op_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [31:0] alu_result;
    logic        alu_flagC;
    logic        alu_flagZ;
    logic        alu_overflow;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
`ifdef ALU_SEQ_STICKY_EN
    logic        sticky_clr;
    logic [1:0]  sticky_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_op1      (cmd_op1),
        .cmd_op2      (cmd_op2),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .alu_flagC    (alu_flagC),
        .alu_flagZ    (alu_flagZ),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
`ifdef ALU_SEQ_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
`endif
        .busy         (busy)
    );

    // Stub ALU: adder with carry, zero and signed-overflow flags
    logic [32:0] stub_sum;
    always_comb begin
        stub_sum     = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        alu_result   = stub_sum[31:0];
        alu_flagC    = stub_sum[32];
        alu_flagZ    = (stub_sum[31:0] == 32'd0);
        alu_zero     = (stub_sum[31:0] == 32'd0);
        alu_overflow = (alu_operand1[31] == alu_operand2[31]) && (stub_sum[31] != alu_operand1[31]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok         = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_op1    = a;
        cmd_op2    = b;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        bit seen;
        seen = 1'b0;
        push_cmd(op, a, b);
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] res_q[$];
        int          t_q[$];
        int          rsp_cnt;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op1    = '0;
        cmd_op2    = '0;
        rsp_ready  = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
        sticky_clr = 1'b0;
`endif
        step();
        step();

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_op1", alu_operand1, 32'd0);
        check("rst_alu_op2", alu_operand2, 32'd0);
`ifdef ALU_SEQ_STICKY_EN
        check("rst_sticky", 32'(sticky_flags), 32'd0);
`endif

        rst_n = 1'b1;
        step();

        // Latency: accept in N, rsp_valid in N+3
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd1;
        cmd_op1    = 32'd0;
        cmd_op2    = 32'd0;
        check("lat_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("lat_n1_valid", 32'(rsp_valid), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        step();
        check("lat_n2_valid", 32'(rsp_valid), 32'd0);
        check("lat_n2_opcode", 32'(alu_opcode), 32'd1);
        step();
        check("lat_n3_valid", 32'(rsp_valid), 32'd1);
        check("lat_result", rsp_result, 32'd0);
        check("lat_flags", 32'(rsp_flags), 32'h6);
        step();
        check("lat_hold_valid", 32'(rsp_valid), 32'd1);
        check("lat_hold_flags", 32'(rsp_flags), 32'h6);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("lat_clear_valid", 32'(rsp_valid), 32'd0);
        check("lat_idle_busy", 32'(busy), 32'd0);
        check("lat_idle_opcode_hold", 32'(alu_opcode), 32'd1);

        // Carry wrap to zero
        send_one("carry", 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0111);
`ifdef ALU_SEQ_STICKY_EN
        step();
        check("sticky_carry", 32'(sticky_flags), 32'h1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_cleared", 32'(sticky_flags), 32'h0);
`endif

        // Signed overflow
        send_one("ovf", 3'd3, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1000);
`ifdef ALU_SEQ_STICKY_EN
        check("sticky_ovf", 32'(sticky_flags), 32'h2);
`endif

        // Back-pressure: five commands with rsp_ready low, then drain
        for (int i = 0; i < 5; i++) push_cmd(3'(i), 32'h1000_0000 + 32'(i), 32'(i));
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid) begin
                res_q.push_back(rsp_result);
                t_q.push_back(t);
            end
            step();
        end
        rsp_ready = 1'b0;
        check("drain_count", 32'(res_q.size()), 32'd5);
        for (int i = 0; i < res_q.size(); i++) begin
            check($sformatf("drain_result_%0d", i), res_q[i], 32'h1000_0000 + 32'(2 * i));
            if (i > 0) check($sformatf("drain_gap_%0d", i), 32'(t_q[i] - t_q[i-1]), 32'd2);
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset during EXEC with three queued; a push in the reset cycle is dropped
        for (int i = 0; i < 5; i++) push_cmd(3'd4, 32'h2000_0000 + 32'(i), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd5;
        cmd_op1    = 32'hDEAD_0000;
        cmd_op2    = 32'd1;
        step();
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mrst_alu_op1", alu_operand1, 32'd0);
`ifdef ALU_SEQ_STICKY_EN
        check("mrst_sticky", 32'(sticky_flags), 32'd0);
`endif
        rsp_ready = 1'b1;
        rsp_cnt   = 0;
        for (int t = 0; t < 12; t++) begin
            if (rsp_valid || busy) rsp_cnt++;
            step();
        end
        rsp_ready = 1'b0;
        check("mrst_no_rsp", 32'(rsp_cnt), 32'd0);

        // Recovery after reset
        send_one("post_rst", 3'd2, 32'd5, 32'd7, 32'd12, 4'b0000);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
